// File: rtl/exec_pkg.sv
// Shared definitions for the execution controller: default widths and FSM state encoding.
// The encoding is visible on the exec_ctrl state output, so it is fixed here and
// must not be reordered.
package exec_pkg;

    localparam int PC_W_DEF  = 4;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

endpackage

// File: rtl/pc_counter.sv
// Program counter register with clear, increment-enable and hold.
// Latency: clr_i/inc_i take effect at the next rising clk edge; clr_i wins over inc_i.
// Ports: clk, clr_i (synchronous clear to 0), inc_i (advance by one), pc_o (current value).
module pc_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] pc_o
);

    logic [W-1:0] pc_q;
    logic [W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (clr_i) begin
            pc_d = '0;
        end else if (inc_i) begin
            pc_d = pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        pc_q <= pc_d;
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/exec_ctrl.sv
// Run/pause/step execution controller with a single breakpoint and retired-instruction counter.
// Latency: load enables are combinational from the current state and inputs; state, pc and
//   cycle_cnt update at the next rising clk edge. rst is synchronous, active high.
// Ports: start/step/halt_req control, prog_len bounds pc, bp_en/bp_addr breakpoint, im_data
//   the instruction at pc; outputs pc, load_a_en/load_b_en, state, cycle_cnt, done.
module exec_ctrl
    import exec_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step,
    input  logic             halt_req,
    input  logic [PC_W-1:0]  prog_len,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic [8:0]       im_data,
    output logic [PC_W-1:0]  pc,
    output logic             load_a_en,
    output logic             load_b_en,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             done
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             skip_q, skip_d;   // suppresses the breakpoint on the first RUN cycle after resume

    logic [PC_W-1:0]  pc_w;
    logic             at_end;
    logic             bp_hit;
    logic             exec;
    logic             pc_clr;
    logic             pc_inc;

    assign at_end = (pc_w == prog_len);
    assign bp_hit = (state_q == ST_RUN) && bp_en && (pc_w == bp_addr) && !skip_q;

    // In RUN, start/step are ignored; in IDLE/PAUSE a simultaneous start takes precedence
    // over step, so that cycle only changes state and retires nothing.
    always_comb begin
        exec = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_RUN:            exec = !halt_req && !bp_hit;
                ST_IDLE, ST_PAUSE: exec = step && !start;
                default:           exec = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        skip_d  = skip_q;
        pc_clr  = rst;

        if (exec && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    pc_clr  = 1'b1;
                    cnt_d   = '0;
                    skip_d  = 1'b0;
                end else if (exec) begin
                    state_d = at_end ? ST_DONE : ST_PAUSE;
                end
            end
            ST_RUN: begin
                skip_d = 1'b0;
                if (halt_req || bp_hit) begin
                    state_d = ST_PAUSE;
                end else if (at_end) begin
                    state_d = ST_DONE;
                end
            end
            ST_PAUSE: begin
                if (start) begin
                    state_d = ST_RUN;
                    skip_d  = 1'b1;
                end else if (exec && at_end) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The last instruction holds pc; only the FSM moves to DONE.
    assign pc_inc = exec && !at_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            skip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            skip_q  <= skip_d;
        end
    end

    pc_counter #(
        .W (PC_W)
    ) u_pc (
        .clk   (clk),
        .clr_i (pc_clr),
        .inc_i (pc_inc),
        .pc_o  (pc_w)
    );

    assign pc        = pc_w;
    assign load_a_en = exec && im_data[6];
    assign load_b_en = exec && im_data[7];
    assign state     = state_q;
    assign cycle_cnt = cnt_q;
    assign done      = (state_q == ST_DONE);

endmodule
